// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: fetch FSM state type, NOP encoding and base opcodes.
package rv32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// Cycle counter for the fetch timeout; expired flags the cycle whose count reaches limit.
module fetch_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] limit,
    output logic        expired
);

    logic [31:0] count_reg;

    // A limit of zero never expires, which disables the timeout.
    assign expired = enable && (limit != 32'd0) && (count_reg == limit - 32'd1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= 32'd0;
        end else if (enable) begin
            count_reg <= count_reg + 32'd1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, imem request FSM, instruction register, timeout abort.
// Optional macro FETCH_MISALIGN_TRAP_EN rejects fetches from non-word-aligned PCs.
module instr_fetch
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic        pc_write,
    input  logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        busy,
    output logic        fetch_err,
    output logic        misaligned
);

    fetch_state_t state_reg;
    logic         timer_expired;

    fetch_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_reg != ST_FETCH),
        .enable  ((state_reg == ST_FETCH) && !imem_ack),
        .limit   (32'(TIMEOUT_CYCLES)),
        .expired (timer_expired)
    );

    assign pc_plus4 = pc + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic [31:0] fetch_pc;
    assign fetch_pc  = pc_write ? pc_next : pc;
    assign imem_addr = pc;
`else
    assign imem_addr = word_align(pc);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            pc          <= RESET_PC;
            instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            busy        <= 1'b0;
            fetch_err   <= 1'b0;
            misaligned  <= 1'b0;
        end else begin
            fetch_err  <= 1'b0;
            misaligned <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (pc_write) begin
                        pc          <= pc_next;
                        instr_valid <= 1'b0;
                    end
                    if (fetch_start) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (fetch_pc[1:0] != 2'b00) begin
                            misaligned  <= 1'b1;
                            state_reg   <= ST_IDLE;
                            instr_valid <= 1'b0;
                        end else begin
                            state_reg   <= ST_FETCH;
                            imem_req    <= 1'b1;
                            busy        <= 1'b1;
                            instr_valid <= 1'b0;
                        end
`else
                        state_reg   <= ST_FETCH;
                        imem_req    <= 1'b1;
                        busy        <= 1'b1;
                        instr_valid <= 1'b0;
`endif
                    end
                end
                ST_FETCH: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (imem_ack) begin
                        instruction <= imem_rdata;
                        instr_valid <= 1'b1;
                        state_reg   <= ST_DONE;
                        imem_req    <= 1'b0;
                        busy        <= 1'b0;
                    end else if (timer_expired) begin
                        fetch_err   <= 1'b1;
                        instr_valid <= 1'b0;
                        state_reg   <= ST_IDLE;
                        imem_req    <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    imem_req  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: number of FETCH cycles without ack before abort; 0 disables the timeout.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 fetch_start  in  1  control FSM request to fetch the instruction at pc.
REQ-007 pc_write  in  1  load pc_next into the PC.
REQ-008 pc_next  in  32  new PC value (branch/jump/PC+4 from datapath).
REQ-009 imem_req  out  1  instruction memory request, registered.
REQ-010 imem_addr  out  32  word address for imem, driven from PC.
REQ-011 imem_ack  in  1  memory has returned data on imem_rdata this cycle.
REQ-012 imem_rdata  in  32  fetched instruction word.
REQ-013 instruction  out  32  instruction register; feeds decode and immediate generation.
REQ-014 pc / pc_plus4  out  32 each  current PC and PC+4 (mod 2^32).
REQ-015 instr_valid  out  1  instruction register holds a fetched word for the current pc.
REQ-016 busy  out  1  high while in FETCH.
REQ-017 fetch_err  out  1  one-cycle pulse on timeout abort.
REQ-018 misaligned  out  1  one-cycle pulse on misaligned fetch (see Configuration); port always present.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, DONE.
REQ-020 IDLE/DONE + fetch_start -> FETCH next cycle; imem_req=1 and busy=1 exactly while in FETCH.
REQ-021 FETCH + imem_ack -> capture imem_rdata into instruction, instr_valid=1, state DONE on the next edge; an ack in the first FETCH cycle is valid (min latency 2 cycles fetch_start->instr_valid).
REQ-022 instr_valid SHALL clear on entry to FETCH and on any pc_write; it holds in DONE until then.
REQ-023 imem_ack outside FETCH SHALL be ignored (no capture, no state change).
REQ-024 pc_write SHALL load pc_next in IDLE and DONE; it SHALL be ignored in FETCH (imem_addr stable for the whole request).
REQ-025 fetch_start and pc_write in the same cycle: both act; the fetch uses pc_next (imem_addr updates with the PC on the same edge FETCH is entered).
REQ-026 fetch_start while in FETCH SHALL be ignored.
REQ-027 timeout counter SHALL reset to 0 on entering FETCH, increment each FETCH cycle without ack; when it reaches TIMEOUT_CYCLES: fetch_err pulse, state IDLE, instruction unchanged, instr_valid=0.
REQ-028 ack in the same cycle as counter reaching the limit: ack wins, no fetch_err.
REQ-029 pc_plus4 SHALL be pc + 32'd4 with wrap-around (32'hFFFF_FFFC -> 32'h0).

Reset
REQ-030 On rst: pc=RESET_PC, instruction=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, busy=0, fetch_err=0, misaligned=0, counter=0, state IDLE.
REQ-031 rst during FETCH SHALL drop imem_req at that edge; an ack arriving afterwards SHALL be ignored.

Configuration
REQ-032 Macro FETCH_MISALIGN_TRAP_EN defined: fetch_start with pc[1:0]!=2'b00 SHALL NOT enter FETCH; misaligned pulses one cycle, state goes IDLE, instr_valid=0.
REQ-033 Macro undefined: imem_addr[1:0] forced to 2'b00, fetch proceeds normally, misaligned tied 0.

Structure
REQ-034 Shared package rv32_pkg SHALL hold fetch_state_t enum, NOP_INSTR constant, and RV32 opcode constants.
REQ-035 Timeout counter SHALL be a sub-module fetch_timer (clear, enable, limit in; expired out).

Verification
REQ-036 Reset, fetch_start, ack 3 cycles later with 32'h00A00093 -> instruction=32'h00A00093, instr_valid=1, pc=0, pc_plus4=4.
REQ-037 pc_write+fetch_start with pc_next=32'h0000_0100, immediate ack -> imem_addr=32'h100 while imem_req=1; instr_valid 2 cycles after fetch_start.
REQ-038 fetch_start, no ack, TIMEOUT_CYCLES=16 -> fetch_err pulse after 16 FETCH cycles, state IDLE, instruction still NOP.
REQ-039 pc_write with pc_next=32'h0000_0200 during FETCH, then ack -> pc stays at old value, captured word valid.
REQ-040 With FETCH_MISALIGN_TRAP_EN, pc_next=32'h0000_0102, fetch_start -> misaligned pulse, imem_req never asserted; without macro -> imem_addr=32'h100.
REQ-041 rst asserted mid-FETCH, ack next cycle -> imem_req=0, instruction=NOP, instr_valid=0.
